gcd_arbiter: RTL and testbench

Round-robin arbiter that shares one `gcd` unit among `NUM_REQ` requesters. Each requester has its own val/rdy request and response channel. The block accepts one request at a time and forwards it to the `gcd` unit's `req_msg` port. It returns the 16-bit result only to the requester that issued it. It sits between client logic and the single `gcd` instance at the top level.

---
 rtl/gcd_arb_pkg.sv | 19 +
 rtl/gcd_arbiter_rr_pick.sv | 38 +++
 rtl/gcd_arbiter.sv | 148 ++++++++++++++
 tb/tb_gcd_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_arb_pkg.sv
// Shared definitions for the gcd_arbiter block.
// - gcd_arb_state_t : arbiter FSM states
// - GCD_MSG_W / GCD_RES_W : widths of the gcd request message and result
// - A_LSB / B_LSB : bit offsets of operands a and b inside a request message
package gcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } gcd_arb_state_t;

  localparam int GCD_MSG_W = 32;
  localparam int GCD_RES_W = 16;
  localparam int A_LSB     = 0;
  localparam int B_LSB     = 16;

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   req       in  NUM_REQ : request vector
//   last      in  IDW     : index of the most recently served requester
//   grant     out NUM_REQ : one-hot winner (all zero when no request)
//   grant_idx out IDW     : index of the winner (0 when no request)
// The search starts at (last+1) mod NUM_REQ and wraps, so the requester
// that was just served has the lowest priority on the next pick.
module rr_pick
  import gcd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_idx
);

  always_comb begin
    logic found;
    int   idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one gcd unit among NUM_REQ requesters, one operation
// in flight at a time, granted round-robin.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   cli_req_val/rdy/msg          : per-requester request channels (32b msg each,
//                                  a in [15:0], b in [31:16])
//   cli_resp_val/rdy, cli_resp_msg : per-requester response valid/ready,
//                                  shared 16b result bus
//   gcd_req_val/rdy/msg          : request channel to the gcd unit
//   gcd_resp_val/rdy/msg         : response channel from the gcd unit
//   busy                         : high whenever the FSM is not IDLE
//   owner                        : index of the current/last grant holder
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             cli_req_val,
  output logic [NUM_REQ-1:0]             cli_req_rdy,
  input  logic [NUM_REQ*GCD_MSG_W-1:0]   cli_req_msg,
  output logic [NUM_REQ-1:0]             cli_resp_val,
  input  logic [NUM_REQ-1:0]             cli_resp_rdy,
  output logic [GCD_RES_W-1:0]           cli_resp_msg,
  output logic                           gcd_req_val,
  input  logic                           gcd_req_rdy,
  output logic [GCD_MSG_W-1:0]           gcd_req_msg,
  input  logic                           gcd_resp_val,
  output logic                           gcd_resp_rdy,
  input  logic [GCD_RES_W-1:0]           gcd_resp_msg,
  output logic                           busy,
  output logic [IDW-1:0]                 owner
);

  gcd_arb_state_t           state_q, state_d;
  logic [IDW-1:0]           last_q;
  logic [IDW-1:0]           owner_q;
  logic [GCD_MSG_W-1:0]     msg_q;
  logic [GCD_RES_W-1:0]     res_q;

  logic [NUM_REQ-1:0]       grant;
  logic [IDW-1:0]           grant_idx;
  logic [GCD_MSG_W-1:0]     sel_msg;
  logic                     cli_accept;
  logic                     gcd_issue;
  logic                     gcd_done;
  logic                     cli_done;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req       (cli_req_val),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // grant only has a bit set where the matching val is high, so a nonzero
  // grant in IDLE is exactly the client transfer.
  assign cli_accept = (state_q == IDLE)   && (|grant);
  assign gcd_issue  = (state_q == ISSUE)  && gcd_req_rdy;
  assign gcd_done   = (state_q == WAIT)   && gcd_resp_val;
  assign cli_done   = (state_q == RETURN) && cli_resp_rdy[owner_q];

  always_comb begin
    sel_msg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_msg = cli_req_msg[i*GCD_MSG_W +: GCD_MSG_W];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cli_accept) state_d = ISSUE;
      ISSUE:   if (gcd_req_rdy)  state_d = WAIT;
      WAIT:    if (gcd_resp_val) state_d = RETURN;
      RETURN:  if (cli_done)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operation context: message, owner, result and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q  <= IDW'(NUM_REQ - 1);
      owner_q <= '0;
      msg_q   <= '0;
      res_q   <= '0;
    end else begin
      if (cli_accept) begin
        msg_q   <= sel_msg;
        owner_q <= grant_idx;
      end
      if (gcd_done) res_q  <= gcd_resp_msg;
      if (cli_done) last_q <= owner_q;
    end
  end

  // Output decode. cli_req_rdy is gated by reset_n so that a client raising
  // val while reset is held still sees every output at 0.
  always_comb begin
    cli_req_rdy  = '0;
    cli_resp_val = '0;
    gcd_req_val  = 1'b0;
    gcd_resp_rdy = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reset_n) cli_req_rdy = grant;
      end
      ISSUE: begin
        gcd_req_val = 1'b1;
        busy        = 1'b1;
      end
      WAIT: begin
        gcd_resp_rdy = 1'b1;
        busy         = 1'b1;
      end
      RETURN: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          cli_resp_val[i] = (owner_q == IDW'(i));
        end
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign gcd_req_msg  = msg_q;
  assign cli_resp_msg = res_q;
  assign owner        = owner_q;

  // gcd_issue is kept as a named event for readability of the ISSUE exit.
  logic unused_issue;
  assign unused_issue = gcd_issue;

endmodule

// File: tb/tb_gcd_arbiter.sv
module tb_gcd_arbiter;
  import gcd_arb_pkg::*;

  localparam int NUM = 4;
  localparam int IW  = 2;

  logic                clk;
  logic                reset_n;
  logic [NUM-1:0]      cli_req_val;
  logic [NUM-1:0]      cli_req_rdy;
  logic [NUM*32-1:0]   cli_req_msg;
  logic [NUM-1:0]      cli_resp_val;
  logic [NUM-1:0]      cli_resp_rdy;
  logic [15:0]         cli_resp_msg;
  logic                gcd_req_val;
  logic                gcd_req_rdy;
  logic [31:0]         gcd_req_msg;
  logic                gcd_resp_val;
  logic                gcd_resp_rdy;
  logic [15:0]         gcd_resp_msg;
  logic                busy;
  logic [IW-1:0]       owner;

  int tests = 0;
  int fails = 0;

  gcd_arbiter #(.NUM_REQ(NUM)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cli_req_val  (cli_req_val),
    .cli_req_rdy  (cli_req_rdy),
    .cli_req_msg  (cli_req_msg),
    .cli_resp_val (cli_resp_val),
    .cli_resp_rdy (cli_resp_rdy),
    .cli_resp_msg (cli_resp_msg),
    .gcd_req_val  (gcd_req_val),
    .gcd_req_rdy  (gcd_req_rdy),
    .gcd_req_msg  (gcd_req_msg),
    .gcd_resp_val (gcd_resp_val),
    .gcd_resp_rdy (gcd_resp_rdy),
    .gcd_resp_msg (gcd_resp_msg),
    .busy         (busy),
    .owner        (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          req_stall;
    int          resp_delay;
    int          ret_stall;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [NUM-1:0] oh(input int i);
    logic [NUM-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic logic [31:0] mk(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] m;
    m = '0;
    m[A_LSB +: 16] = a;
    m[B_LSB +: 16] = b;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    cli_req_val  = '0;
    cli_req_msg  = '0;
    cli_resp_rdy = '0;
    gcd_req_rdy  = 1'b0;
    gcd_resp_val = 1'b0;
    gcd_resp_msg = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One complete operation by a single requester, with optional stalls on
  // the gcd request, gcd response and client response channels.
  task automatic run_op(input vec_t v, input string tag);
    logic [31:0] m;
    int          other;
    m     = mk(v.a, v.b);
    other = (v.r + 1) % NUM;
    @(negedge clk);
    cli_req_msg[v.r*32 +: 32] = m;
    cli_req_val[v.r] = 1'b1;
    #1 chk({tag, ".req_rdy"}, 32'(cli_req_rdy), 32'(oh(v.r)));
    @(posedge clk);
    @(negedge clk);
    cli_req_val[v.r] = 1'b0;
    #1;
    chk({tag, ".gcd_req_val"}, 32'(gcd_req_val), 32'd1);
    chk({tag, ".gcd_req_msg"}, gcd_req_msg, m);
    chk({tag, ".owner"}, 32'(owner), 32'(v.r));
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    for (int s = 0; s < v.req_stall; s++) begin
      @(negedge clk);
      #1;
      chk({tag, ".issue_msg_hold"}, gcd_req_msg, m);
      chk({tag, ".issue_val_hold"}, 32'(gcd_req_val), 32'd1);
      chk({tag, ".issue_busy"}, 32'(busy), 32'd1);
    end
    gcd_req_rdy = 1'b1;
    @(negedge clk);
    gcd_req_rdy = 1'b0;
    #1;
    chk({tag, ".wait_resp_rdy"}, 32'(gcd_resp_rdy), 32'd1);
    chk({tag, ".wait_req_val"}, 32'(gcd_req_val), 32'd0);
    for (int s = 0; s < v.resp_delay; s++) begin
      @(negedge clk);
      #1;
      chk({tag, ".wait_busy"}, 32'(busy), 32'd1);
      chk({tag, ".wait_resp_val"}, 32'(cli_resp_val), 32'd0);
      chk({tag, ".wait_msg_hold"}, gcd_req_msg, m);
    end
    gcd_resp_val = 1'b1;
    gcd_resp_msg = v.res;
    @(negedge clk);
    gcd_resp_val = 1'b0;
    gcd_resp_msg = 16'hDEAD;
    #1;
    chk({tag, ".resp_val"}, 32'(cli_resp_val), 32'(oh(v.r)));
    chk({tag, ".resp_msg"}, 32'(cli_resp_msg), 32'(v.res));
    if (v.ret_stall > 0) begin
      cli_resp_rdy = ~oh(v.r);
      cli_req_msg[other*32 +: 32] = mk(16'd1, 16'd1);
      cli_req_val[other] = 1'b1;
    end
    for (int s = 0; s < v.ret_stall; s++) begin
      @(negedge clk);
      #1;
      chk({tag, ".ret_val_hold"}, 32'(cli_resp_val), 32'(oh(v.r)));
      chk({tag, ".ret_msg_hold"}, 32'(cli_resp_msg), 32'(v.res));
      chk({tag, ".ret_no_req_rdy"}, 32'(cli_req_rdy), 32'd0);
    end
    cli_req_val  = '0;
    cli_resp_rdy = oh(v.r);
    @(negedge clk);
    cli_resp_rdy = '0;
    #1;
    chk({tag, ".done_busy"}, 32'(busy), 32'd0);
    chk({tag, ".done_resp_val"}, 32'(cli_resp_val), 32'd0);
  endtask

  // Serves the currently pending requests once, expecting exp_o to win.
  // Called in IDLE after the request vals have been set.
  task automatic serve(input int exp_o, input logic [31:0] exp_msg,
                       input logic [15:0] res, input bit drop, input string tag);
    #1 chk({tag, ".req_rdy"}, 32'(cli_req_rdy), 32'(oh(exp_o)));
    @(posedge clk);
    @(negedge clk);
    if (drop) cli_req_val[exp_o] = 1'b0;
    #1;
    chk({tag, ".owner"}, 32'(owner), 32'(exp_o));
    chk({tag, ".gcd_req_msg"}, gcd_req_msg, exp_msg);
    chk({tag, ".no_req_rdy"}, 32'(cli_req_rdy), 32'd0);
    gcd_req_rdy = 1'b1;
    @(negedge clk);
    gcd_req_rdy  = 1'b0;
    gcd_resp_val = 1'b1;
    gcd_resp_msg = res;
    @(negedge clk);
    gcd_resp_val = 1'b0;
    #1;
    chk({tag, ".resp_val"}, 32'(cli_resp_val), 32'(oh(exp_o)));
    chk({tag, ".resp_msg"}, 32'(cli_resp_msg), 32'(res));
    cli_resp_rdy = '1;
    @(negedge clk);
    cli_resp_rdy = '0;
    #1 chk({tag, ".done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    tbl[0] = '{r: 0, a: 16'd5,      b: 16'd10,     res: 16'd5,      req_stall: 0, resp_delay: 0,  ret_stall: 0};
    tbl[1] = '{r: 1, a: 16'd12,     b: 16'd18,     res: 16'd6,      req_stall: 0, resp_delay: 0,  ret_stall: 0};
    tbl[2] = '{r: 3, a: 16'hFFFF,   b: 16'hFFFF,   res: 16'hFFFF,   req_stall: 0, resp_delay: 0,  ret_stall: 5};
    tbl[3] = '{r: 0, a: 16'd48,     b: 16'd36,     res: 16'd12,     req_stall: 1, resp_delay: 2,  ret_stall: 1};
    tbl[4] = '{r: 2, a: 16'd0,      b: 16'd9,      res: 16'd9,      req_stall: 3, resp_delay: 10, ret_stall: 0};

    // Reset state, including a client raising val while reset is held
    reset_n      = 1'b0;
    cli_req_val  = '0;
    cli_req_msg  = '0;
    cli_resp_rdy = '0;
    gcd_req_rdy  = 1'b0;
    gcd_resp_val = 1'b0;
    gcd_resp_msg = '0;
    #3;
    cli_req_val = 4'b0001;
    #1;
    chk("rst.req_rdy", 32'(cli_req_rdy), 32'd0);
    chk("rst.resp_val", 32'(cli_resp_val), 32'd0);
    chk("rst.resp_msg", 32'(cli_resp_msg), 32'd0);
    chk("rst.gcd_req_val", 32'(gcd_req_val), 32'd0);
    chk("rst.gcd_req_msg", gcd_req_msg, 32'd0);
    chk("rst.gcd_resp_rdy", 32'(gcd_resp_rdy), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.owner", 32'(owner), 32'd0);
    cli_req_val = '0;
    do_reset();

    // Requesters 0 and 2 together: 0 first (reset priority), then 2
    @(negedge clk);
    cli_req_msg[0*32 +: 32] = mk(16'd15, 16'd150);
    cli_req_msg[2*32 +: 32] = mk(16'd12, 16'd18);
    cli_req_val = 4'b0101;
    serve(0, mk(16'd15, 16'd150), 16'd15, 1'b1, "pair0");
    serve(2, mk(16'd12, 16'd18), 16'd6, 1'b1, "pair2");

    // All four continuously valid: order 0,1,2,3,0,1,2,3
    do_reset();
    @(negedge clk);
    for (int r = 0; r < NUM; r++)
      cli_req_msg[r*32 +: 32] = mk(16'(r + 1), 16'((r + 1) * 6));
    cli_req_val = '1;
    for (int k = 0; k < 8; k++)
      serve(k % NUM, mk(16'((k % NUM) + 1), 16'(((k % NUM) + 1) * 6)),
            16'((k % NUM) + 1), 1'b0, $sformatf("rr%0d", k));
    cli_req_val = '0;

    // Table of single-requester operations with stalls
    for (int i = 0; i < 5; i++)
      run_op(tbl[i], $sformatf("vec%0d", i));

    // Reset during WAIT. last is 2 here, so without a reset of the pointer
    // requester 3 would win over requester 1.
    @(negedge clk);
    cli_req_msg[0*32 +: 32] = mk(16'd8, 16'd4);
    cli_req_val[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cli_req_val[0] = 1'b0;
    gcd_req_rdy    = 1'b1;
    @(negedge clk);
    gcd_req_rdy = 1'b0;
    #1 chk("mid.in_wait", 32'(gcd_resp_rdy), 32'd1);
    reset_n = 1'b0;
    cli_req_msg[1*32 +: 32] = mk(16'd7, 16'd21);
    cli_req_msg[3*32 +: 32] = mk(16'd10, 16'd25);
    cli_req_val = 4'b1010;
    #1;
    chk("mid.gcd_resp_rdy", 32'(gcd_resp_rdy), 32'd0);
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.owner", 32'(owner), 32'd0);
    chk("mid.gcd_req_msg", gcd_req_msg, 32'd0);
    chk("mid.resp_msg", 32'(cli_resp_msg), 32'd0);
    chk("mid.req_rdy", 32'(cli_req_rdy), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    serve(1, mk(16'd7, 16'd21), 16'd7, 1'b1, "post1");
    serve(3, mk(16'd10, 16'd25), 16'd5, 1'b1, "post3");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
